npm_toggle_pm_dispatcher: RTL

Primitive dispatcher for the NAND flash controller physical-module (PM) layer. Sits directly upstream of the PM primitive engines (PO reset, PI reset, etc.). It accepts one primitive command at a time from the NFC command layer and drives the selected engine's start line. It chains the requested number of back-to-back runs through the engine's last-step/restart path, reports completion, and flags engines that stall.

---
 rtl/npm_toggle_pm_dispatcher.sv | 114 +++++++++++
 1 files changed

// File: rtl/npm_toggle_pm_dispatcher.sv
// Dispatches one primitive command at a time to a PM engine. Repeat runs are chained through
// the engine's last-step/restart path. A watchdog parks a stalled run in ERROR until it is cleared.
module npm_toggle_pm_dispatcher #(
  parameter int NUM_PM = 4,
  parameter int CNT_W = 8,
  parameter int TMO_W = 16,
  parameter logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(1023),
  localparam int SEL_W = (NUM_PM > 1) ? $clog2(NUM_PM) : 1
) (
  input  logic              iSystemClock,
  input  logic              iReset,
  input  logic              iCmdValid,
  output logic              oCmdReady,
  input  logic [SEL_W-1:0]  iCmdPM,
  input  logic [CNT_W-1:0]  iCmdCount,
  output logic              oCmdDone,
  output logic              oError,
  input  logic              iErrorClear,
  output logic [NUM_PM-1:0] oStart,
  input  logic [NUM_PM-1:0] iPMReady,
  input  logic [NUM_PM-1:0] iPMLastStep,
  output logic              oBusy
);

  typedef enum logic [2:0] {
    ST_RESET = 3'd0,
    ST_IDLE  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } state_t;

  state_t            state, state_nxt;
  logic [SEL_W-1:0]  sel, sel_nxt;
  logic [CNT_W-1:0]  remain, remain_nxt;
  logic [TMO_W-1:0]  wdog, wdog_nxt;
  logic [NUM_PM-1:0] sel_hot;
  logic              sel_last;
  logic              cmd_ready;

  // An out-of-range selector decodes to all zeros: no start, no last step, watchdog fires.
  always_comb begin
    sel_hot = '0;
    for (int i = 0; i < NUM_PM; i++) begin
      sel_hot[i] = (sel == SEL_W'(i));
    end
  end

  assign sel_last  = |(iPMLastStep & sel_hot);
  assign cmd_ready = (state == ST_IDLE) && (&iPMReady);

  always_ff @(posedge iSystemClock) begin
    if (iReset) begin
      state  <= ST_RESET;
      sel    <= '0;
      remain <= '0;
      wdog   <= '0;
    end else begin
      state  <= state_nxt;
      sel    <= sel_nxt;
      remain <= remain_nxt;
      wdog   <= wdog_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    sel_nxt    = sel;
    remain_nxt = remain;
    wdog_nxt   = wdog;
    case (state)
      ST_RESET: state_nxt = ST_IDLE;
      ST_IDLE: begin
        if (iCmdValid && cmd_ready) begin
          sel_nxt    = iCmdPM;
          remain_nxt = (iCmdCount == '0) ? CNT_W'(1) : iCmdCount;
          state_nxt  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wdog_nxt  = '0;
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (sel_last) begin
          if (remain <= CNT_W'(1)) begin
            state_nxt = ST_DONE;
          end else begin
            remain_nxt = remain - CNT_W'(1);
            wdog_nxt   = '0;
          end
        end else if (wdog == TMO_LIMIT) begin
          state_nxt = ST_ERROR;
        end else begin
          wdog_nxt = wdog + TMO_W'(1);
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      ST_ERROR: begin
        if (iErrorClear) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Start stays high through a non-final last step so the engine restarts with no gap.
  assign oStart    = ((state == ST_ISSUE) || ((state == ST_RUN) && (remain > CNT_W'(1)))) ? sel_hot : '0;
  assign oCmdReady = cmd_ready;
  assign oCmdDone  = (state == ST_DONE);
  assign oError    = (state == ST_ERROR);
  assign oBusy     = (state != ST_IDLE);

endmodule
